multdiv_exec_unit: RTL and testbench
====================================

Name: multdiv_exec_unit

Overview:
- Iterative signed 32-bit multiply/divide engine in the execute stage.
- Consumes operands from the post-bypass ALU A/B operand muxes; triggered by R-type ALU-op mul (00110) or div (00111).
- Holds the pipeline with a stall while it iterates; returns result plus exception flag to the X/M latch.
- The exception flag becomes the XM overflow bit, so the writeback target is redirected to r30.

Parameters:
- WIDTH, 32, operand and result width.
- MULT_ITERS, 32, multiply iteration count in radix-2 mode.
- DIV_ITERS, 32, restoring-divide iteration count.

Ports:
- clock  in  1  pipeline clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ctrl_MULT  in  1  start-multiply strobe, sampled on the rising edge.
- ctrl_DIV  in  1  start-divide strobe, sampled on the rising edge.
- flush  in  1  branch/jump squash; aborts the operation in flight.
- data_operandA  in  WIDTH  bypassed rs value; multiplicand or dividend.
- data_operandB  in  WIDTH  bypassed rt value; multiplier or divisor.
- data_result  out  WIDTH  low 32 bits of the product, or the quotient.
- data_exception  out  1  mult overflow, div-by-zero, or div overflow.
- data_resultRDY  out  1  one-cycle completion pulse.
- stall  out  1  freeze PC, F/D and D/X latches.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, stall=0.
- States: IDLE, RUN, FIX, DONE. Operands and op type are latched only on an accepted start edge.
- IDLE/DONE + ctrl_MULT or ctrl_DIV -> RUN; counter=0.
  - If both strobes are high, MULT wins.
  - In DONE, a new start is accepted, giving back-to-back operation.
- Start strobes seen in RUN or FIX are ignored.
- RUN: one iteration per edge. When counter reaches ITERS-1, go to FIX.
- Multiply: signed shift-add on a 64-bit accumulator, using |A|, |B| and a sign fix in FIX.
- Divide: restoring division on |A|, |B|. The quotient sign is A[31]^B[31], so results truncate toward zero. The remainder is discarded.
- FIX: apply the sign and compute the exception, then go to DONE. Exception cases:
  - mult: high 33 bits of the signed product are not all equal.
  - div: B==0, or A==0x80000000 and B==-1.
- Result on exception:
  - Div-by-zero: data_result=0.
  - Div overflow: data_result=0x80000000.
  - Mult overflow: low 32 bits of the product.
- DONE: data_resultRDY=1 for exactly one cycle; data_result and data_exception are valid. Next edge -> IDLE, unless a new start is accepted.
- Div-by-zero short-circuit: DIV start with B==0 goes straight to DONE on edge 1.
- Latency, with the start sampled at edge 0:
  - mult/div: RUN on edges 1..32, FIX at edge 33, RDY high between edges 33 and 34.
  - div-by-zero: RDY high between edges 1 and 2.
- stall = (start strobe accepted this cycle) OR state in {RUN, FIX}. stall is low in DONE so the instruction advances with its result.
- data_result and data_exception hold their last value outside DONE.
- flush in any state -> IDLE on the next edge, with no RDY pulse. flush takes priority over a simultaneous start.
- Reset mid-operation: immediate return to IDLE; outputs cleared; no RDY pulse.

Optional Feature:
- Macro: MULTDIV_BOOTH4_EN.
- Defined: multiply uses radix-4 Booth recoding over 16 iterations, so mult RDY is high between edges 17 and 18. Divide is unchanged.
- Undefined: radix-2 multiply, 32 iterations.
- Results and exceptions are bit-identical in both modes.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE/RUN/FIX/DONE);
  - ALU-op constants MUL_OP=5'b00110 and DIV_OP=5'b00111;
  - the R-type opcode 5'b00000;
  - iteration counts;
  - REG_STATUS=5'd30.
- One natural sub-module: multdiv_step, a combinational single-iteration datapath. It performs the add/shift for mult, or the trial-subtract for div, selected by op.

Test Plan:
- MULT A=7, B=-6 -> data_result=0xFFFFFFD6 (-42), exception=0, RDY one cycle between edges 33 and 34, stall high over edges 0..33.
- MULT A=0x00010000, B=0x00010000 -> data_result=0, exception=1. With MULTDIV_BOOTH4_EN, same values, RDY between edges 17 and 18.
- DIV A=-100, B=7 -> data_result=0xFFFFFFF2 (-14), exception=0.
- DIV A=5, B=0 -> data_result=0, exception=1, RDY between edges 1 and 2.
- DIV A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1.
- Abort and strobe-conflict checks:
  - Start MULT, then flush at edge 10 -> IDLE, no RDY, stall drops.
  - Assert reset at edge 5 -> all outputs 0.
  - ctrl_MULT and ctrl_DIV together -> multiply performed.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide execute unit.
// Build option MULTDIV_BOOTH4_EN selects radix-4 Booth multiply in the consumers.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DATA_W = 32;

    // Decode constants used by the D/X stage to raise ctrl_MULT/ctrl_DIV
    localparam logic [4:0] RTYPE_OPCODE = 5'b00000;
    localparam logic [4:0] MUL_OP       = 5'b00110;
    localparam logic [4:0] DIV_OP       = 5'b00111;

    localparam int unsigned MULT_ITERS_R2    = 32;
    localparam int unsigned MULT_ITERS_BOOTH = 16;
    localparam int unsigned DIV_ITERS_DEF    = 32;

    // Writeback target when the exception flag is set
    localparam logic [4:0] REG_STATUS = 5'd30;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration: shift-add (or Booth radix-4 digit when
// MULTDIV_BOOTH4_EN is defined) for multiply, restoring trial-subtract for divide.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [2*WIDTH-1:0]   mcand,
    input  logic [WIDTH:0]       mpl,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic [2*WIDTH-1:0]   mcand_next,
    output logic [WIDTH:0]       mpl_next
);

    localparam int unsigned AW = 2 * WIDTH;

    logic [AW:0]      shifted;
    logic [WIDTH:0]   trial;
    logic [AW-1:0]    pp;

    always_comb begin
        acc_next   = acc;
        mcand_next = mcand;
        mpl_next   = mpl;
        shifted    = '0;
        trial      = '0;
        pp         = '0;
        if (is_div) begin
            // acc = {remainder, dividend/quotient}; divisor sits in mcand low half
            shifted = {acc, 1'b0};
            trial   = shifted[AW:WIDTH] - {1'b0, mcand[WIDTH-1:0]};
            if (!trial[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            end else begin
                acc_next = shifted[AW-1:0];
            end
        end else begin
`ifdef MULTDIV_BOOTH4_EN
            // mpl[2:0] = {b(i+1), b(i), b(i-1)} of the signed multiplier
            case (mpl[2:0])
                3'b001, 3'b010: pp = mcand;
                3'b011:         pp = mcand << 1;
                3'b100:         pp = -(mcand << 1);
                3'b101, 3'b110: pp = -mcand;
                default:        pp = '0;
            endcase
            acc_next   = acc + pp;
            mcand_next = mcand << 2;
            mpl_next   = mpl >> 2;
`else
            pp         = mpl[0] ? mcand : '0;
            acc_next   = acc + pp;
            mcand_next = mcand << 1;
            mpl_next   = mpl >> 1;
`endif
        end
    end

endmodule

// File: rtl/multdiv_exec_unit.sv
// Iterative signed 32-bit multiply/divide engine for the execute stage.
// Define MULTDIV_BOOTH4_EN for a 16-iteration radix-4 Booth multiply.
module multdiv_exec_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH      = DATA_W,
    parameter int unsigned MULT_ITERS = MULT_ITERS_R2,
    parameter int unsigned DIV_ITERS  = DIV_ITERS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             stall
);

    localparam int unsigned AW    = 2 * WIDTH;
    localparam int unsigned CNT_W = 6;

`ifdef MULTDIV_BOOTH4_EN
    localparam int unsigned MULT_STEPS    = MULT_ITERS / 2;
    localparam logic        MULT_SIGN_FIX = 1'b0;
`else
    localparam int unsigned MULT_STEPS    = MULT_ITERS;
    localparam logic        MULT_SIGN_FIX = 1'b1;
`endif

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               is_div;
    logic               neg;
    logic               div_zero;
    logic               div_ovf;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      mcand;
    logic [WIDTH:0]     mpl;

    logic [AW-1:0]      acc_next;
    logic [AW-1:0]      mcand_next;
    logic [WIDTH:0]     mpl_next;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [AW-1:0]      mul_mcand_init;
    logic [WIDTH:0]     mul_mpl_init;
    logic               start;
    logic               start_div;
    logic               last_iter;
    logic [AW-1:0]      prod;
    logic [WIDTH:0]     prod_top;
    logic               mult_ovf;
    logic [WIDTH-1:0]   quo;

    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_BOOTH4_EN
    // Booth works on the signed operands directly, so no sign fix is needed
    assign mul_mcand_init = {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
    assign mul_mpl_init   = {data_operandB, 1'b0};
`else
    assign mul_mcand_init = {{WIDTH{1'b0}}, abs_a};
    assign mul_mpl_init   = {1'b0, abs_b};
`endif

    assign start     = (ctrl_MULT | ctrl_DIV) & ~flush & ((state == IDLE) | (state == DONE));
    assign start_div = ~ctrl_MULT;
    assign stall     = start | (state == RUN) | (state == FIX);
    assign last_iter = counter == CNT_W'((is_div ? DIV_ITERS : MULT_STEPS) - 1);

    // Sign fix and exception detection consumed in FIX
    assign prod     = neg ? -acc : acc;
    assign prod_top = prod[AW-1:WIDTH-1];
    assign mult_ovf = ~((&prod_top) | ~(|prod_top));
    assign quo      = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div),
        .acc        (acc),
        .mcand      (mcand),
        .mpl        (mpl),
        .acc_next   (acc_next),
        .mcand_next (mcand_next),
        .mpl_next   (mpl_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            is_div         <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            acc            <= '0;
            mcand          <= '0;
            mpl            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            counter  <= '0;
                            is_div   <= start_div;
                            neg      <= (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1])
                                        & (start_div | MULT_SIGN_FIX);
                            div_zero <= data_operandB == '0;
                            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                                        & (&data_operandB);
                            if (start_div) begin
                                acc   <= {{WIDTH{1'b0}}, abs_a};
                                mcand <= {{WIDTH{1'b0}}, abs_b};
                                mpl   <= '0;
                            end else begin
                                acc   <= '0;
                                mcand <= mul_mcand_init;
                                mpl   <= mul_mpl_init;
                            end
                            // Divide by zero skips the iterations entirely
                            state <= (start_div && data_operandB == '0) ? FIX : RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    RUN: begin
                        acc     <= acc_next;
                        mcand   <= mcand_next;
                        mpl     <= mpl_next;
                        counter <= counter + CNT_W'(1);
                        if (last_iter) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        state          <= DONE;
                        data_resultRDY <= 1'b1;
                        if (!is_div) begin
                            data_result    <= prod[WIDTH-1:0];
                            data_exception <= mult_ovf;
                        end else if (div_zero) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else if (div_ovf) begin
                            data_result    <= {1'b1, {(WIDTH-1){1'b0}}};
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= quo;
                            data_exception <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_exec_unit.sv
// Self-checking bench for multdiv_exec_unit against an arithmetic reference model.
// Latency expectations follow MULTDIV_BOOTH4_EN when it is defined.
module tb_multdiv_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        flush;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MULTDIV_BOOTH4_EN
    localparam int MULT_LAT = 17;
`else
    localparam int MULT_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    multdiv_exec_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .flush          (flush),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .stall          (stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic, C-style truncating divide
    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        longint q;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = q[31:0];
            e = 1'b0;
        end
    endfunction

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, input string tag);
        logic [31:0] er;
        logic        ee;
        int          lat;
        int          rdy_edge;
        bit          stall_ok;
        model(m, a, b, er, ee);
        lat = m ? MULT_LAT : ((b == 32'd0) ? 1 : DIV_LAT);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        #1 chk({tag, "_stall_start"}, 32'(stall), 32'd1);
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        rdy_edge = 0;
        stall_ok = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                rdy_edge = n;
                break;
            end
            if (!stall) stall_ok = 1'b0;
        end
        chk({tag, "_latency"}, 32'(rdy_edge), 32'(lat));
        chk({tag, "_result"}, data_result, er);
        chk({tag, "_exception"}, 32'(data_exception), 32'(ee));
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
        if (!b2b) begin
            @(posedge clock);
            #1 chk({tag, "_rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [15:0] h;
        bit          rm;
        int          sel;
        int          rdy_cnt;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        flush         = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #12;
        chk("rst_result", data_result, 32'd0);
        chk("rst_exception", 32'(data_exception), 32'd0);
        chk("rst_rdy", 32'(data_resultRDY), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b0, "mul_7x-6");
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul_ovf");
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, "div_-100/7");
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, "div_by_zero");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "mul_min_ovf");
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, 1'b0, "mul_min_x1");
        run_op(1'b1, 1'b1, 32'd12, 32'd0, 1'b0, "both_strobes");
        run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFFD, 1'b1, "b2b_first");
        run_op(1'b1, 1'b0, 32'hFFFF_FFF3, 32'd11, 1'b0, "b2b_second");

        for (int i = 0; i < 24; i++) begin
            rm  = 1'($urandom_range(1));
            sel = $urandom_range(3);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 1) begin
                h  = 16'($urandom);
                ra = {{16{h[15]}}, h};
                h  = 16'($urandom);
                rb = {{16{h[15]}}, h};
            end else if (sel == 2) begin
                h  = 16'($urandom_range(3));
                rb = {{16{1'b0}}, h};
            end else if (sel == 3) begin
                ra = 32'h8000_0000;
            end
            run_op(rm, ~rm, ra, rb, (i % 4) == 1, "rand");
        end

        // Flush during a multiply: back to IDLE with no completion pulse
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        @(posedge clock);
        #1 ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_rdy", 32'(data_resultRDY), 32'd0);
        flush = 1'b0;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clock);
            #1 if (data_resultRDY) rdy_cnt++;
        end
        chk("flush_no_rdy", 32'(rdy_cnt), 32'd0);

        // Reset mid-operation after a nonzero result is held
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b0, "pre_reset");
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd3;
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_exception", 32'(data_exception), 32'd0);
        chk("midrst_rdy", 32'(data_resultRDY), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clock);
            #1 if (data_resultRDY || stall) rdy_cnt++;
        end
        chk("midrst_quiet", 32'(rdy_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
